// File: rtl/aes_stream_pkg.sv
// Shared widths and helpers for the AES block streaming path.
// Slot operation encoding is shared by the serializer and its block slots.
package aes_stream_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int STREAM_W    = 16;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_LOAD,
    SLOT_SHIFT,
    SLOT_DROP
  } slot_op_e;

  // Width of a counter that must hold 0..beats-1; never narrower than 1 bit.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 2) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/stream_block_slot.sv
// One block slot: data, type tag and valid flag with load, shift and drop.
// Shifting moves data toward the output end and zero-fills the vacated beat.
module stream_block_slot
  import aes_stream_pkg::*;
#(
  parameter int DATA_W    = AES_BLOCK_W,
  parameter int SHIFT_W   = STREAM_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_op_e          op,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_tag,
  output logic [DATA_W-1:0] data,
  output logic              tag,
  output logic              valid
);

  logic [DATA_W-1:0] shifted;

  assign shifted = MSB_FIRST ? (data << SHIFT_W) : (data >> SHIFT_W);

  // NOTE: the data register is reset too, because an idle slot must present zeros
  // and the shift path relies on a clean zero fill; non-blocking updates throughout.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      tag   <= 1'b0;
      valid <= 1'b0;
    end else begin
      unique case (op)
        SLOT_LOAD: begin
          data  <= load_data;
          tag   <= load_tag;
          valid <= 1'b1;
        end
        SLOT_SHIFT: data <= shifted;
        SLOT_DROP: begin
          data  <= '0;
          valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// Serializes DIN_W-bit tagged blocks into DOUT_W-bit beats with valid/ready
// handshakes on both sides; one active (shifting) slot plus one holding slot.
module stream_serializer
  import aes_stream_pkg::*;
#(
  parameter int DIN_W     = AES_BLOCK_W,
  parameter int DOUT_W    = STREAM_W,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vin,
  output logic              rin,
  input  logic              tin,
  input  logic [DIN_W-1:0]  din,
  output logic              vout,
  input  logic              rout,
  output logic              tout,
  output logic              lout,
  output logic [DOUT_W-1:0] dout
);

  localparam int N  = DIN_W / DOUT_W;
  localparam int CW = beat_cnt_w(N);

  generate
    if ((DIN_W % DOUT_W) != 0 || N < 2) begin : g_bad_widths
      $error("stream_serializer: DIN_W must be a multiple of DOUT_W with at least 2 beats");
    end
  endgenerate

  logic [DIN_W-1:0] act_data, hold_data, act_load_data;
  logic             act_tag, hold_tag, act_load_tag;
  logic             act_valid, hold_valid;
  slot_op_e         act_op, hold_op;
  logic [CW-1:0]    count;
  logic             accept, xfer, last_beat, last_xfer;

  assign rin       = !rst && !hold_valid;
  assign accept    = vin && rin;
  assign vout      = !rst && act_valid;
  assign xfer      = vout && rout;
  assign last_beat = (count == CW'(N - 1));
  assign last_xfer = xfer && last_beat;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    act_op        = SLOT_IDLE;
    hold_op       = SLOT_IDLE;
    act_load_data = din;
    act_load_tag  = tin;

    // A new block goes straight to the active slot when it is free or freeing up.
    if (accept && (!act_valid || last_xfer)) begin
      act_op = SLOT_LOAD;
    end else if (last_xfer && hold_valid) begin
      act_op        = SLOT_LOAD;
      act_load_data = hold_data;
      act_load_tag  = hold_tag;
    end else if (last_xfer) begin
      act_op = SLOT_DROP;
    end else if (xfer) begin
      act_op = SLOT_SHIFT;
    end

    // accept implies an empty holding slot, so these two arms never overlap.
    if (accept && act_valid && !last_xfer) begin
      hold_op = SLOT_LOAD;
    end else if (last_xfer && hold_valid) begin
      hold_op = SLOT_DROP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (last_xfer) begin
      count <= '0;
    end else if (xfer) begin
      count <= count + 1'b1;
    end
  end

  stream_block_slot #(
    .DATA_W   (DIN_W),
    .SHIFT_W  (DOUT_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_active (
    .clk      (clk),
    .rst      (rst),
    .op       (act_op),
    .load_data(act_load_data),
    .load_tag (act_load_tag),
    .data     (act_data),
    .tag      (act_tag),
    .valid    (act_valid)
  );

  stream_block_slot #(
    .DATA_W   (DIN_W),
    .SHIFT_W  (DOUT_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .op       (hold_op),
    .load_data(din),
    .load_tag (tin),
    .data     (hold_data),
    .tag      (hold_tag),
    .valid    (hold_valid)
  );

  assign dout = !vout ? '0 :
                MSB_FIRST ? act_data[DIN_W-1 -: DOUT_W] : act_data[DOUT_W-1:0];
  assign tout = !rst && act_tag;
  assign lout = vout && last_beat;

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 Parameter DIN_W, 128, input block width in bits.
REQ-002 Parameter DOUT_W, 16, output beat width in bits; beats per block N = DIN_W/DOUT_W.
REQ-003 Parameter MSB_FIRST, 0, beat order: 0 = din[DOUT_W-1:0] first; 1 = din[DIN_W-1:DIN_W-DOUT_W] first.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 vin  input  1  input block valid.
REQ-007 rin  output 1  input ready; block accepted on clk edge with vin && rin.
REQ-008 tin  input  1  block type tag, captured with block.
REQ-009 din  input  DIN_W  input block.
REQ-010 vout output 1  output beat valid.
REQ-011 rout input  1  downstream ready; beat transferred on clk edge with vout && rout.
REQ-012 tout output 1  type tag of block currently being emitted.
REQ-013 lout output 1  last beat of block.
REQ-014 dout output DOUT_W  output beat.

Function
REQ-015 Storage SHALL be two block slots: active (shifting) slot and one holding slot, each with data, type, valid.
REQ-016 rin SHALL equal !rst && !hold_valid.
REQ-017 Accepted block SHALL load active slot when active empty or its last beat transfers that cycle; otherwise holding slot.
REQ-018 On last-beat transfer with holding slot valid, holding slot SHALL move to active slot that cycle and rin SHALL assert next cycle.
REQ-019 Accept and last-beat transfer in same cycle with holding slot valid SHALL be impossible (rin low); no block SHALL be dropped or duplicated.
REQ-020 Latency: block accepted at edge t into empty unit SHALL present beat 0 with vout=1 after edge t (cycle t+1).
REQ-021 With rout held 1 and vin held 1, output SHALL be continuous, N beats per block, no bubble between blocks.
REQ-022 Each beat transfer SHALL shift active data by DOUT_W toward the output end, zero-filling vacated bits.
REQ-023 Beat counter 0..N-1 SHALL advance only on beat transfer; lout = vout && (count == N-1); counter wraps to 0 after last beat.
REQ-024 While vout && !rout, dout, tout, lout SHALL hold stable.
REQ-025 tout SHALL equal type of active block and change only when a new block enters active slot.
REQ-026 vout SHALL be deasserted when active slot empty; dout then 0.
REQ-027 DIN_W not a multiple of DOUT_W, or N < 2, SHALL cause an elaboration error.

Reset
REQ-028 While rst=1: both slots invalid, data 0, count 0; vout=0, lout=0, tout=0, dout=0, rin=0.
REQ-029 rst asserted mid-block SHALL discard active and held blocks; rin=1 in first cycle after rst deasserts.
REQ-030 vin and rout SHALL be ignored while rst=1.

Structure
REQ-031 Package aes_stream_pkg SHALL hold AES_BLOCK_W=128, STREAM_W=16 and the beat-count width function used by this block.
REQ-032 One sub-module, stream_block_slot (data/type/valid register with load and shift), SHALL be instantiated for active and holding slots.

Verification
REQ-033 Single block din=128'h00112233_44556677_8899AABB_CCDDEEFF, tin=1, rout=1 -> 8 beats EEFF, CCDD, AABB, 8899, 6677, 4455, 2233, 0011; tout=1; lout only on beat 8.
REQ-034 Same block with MSB_FIRST=1 -> first beat 0011, last beat EEFF.
REQ-035 Three blocks back-to-back, vin=1, rout=1 -> 24 consecutive beats, no vout gap; second block held, rin low for 7 cycles after second accept.
REQ-036 rout toggled 1,0,0,1 during block -> dout/lout/tout unchanged while stalled; beat order intact.
REQ-037 rst pulse at beat 3 with held block -> vout=0 next cycle, no stale beats after release; new block emits from beat 0.
REQ-038 DIN_W=64, DOUT_W=8, din=64'h0102030405060708 -> beats 08..01, lout on 8th.
